// File: rtl/reloj_pkg.sv
// Shared definitions for the clock/calendar time-setting path.
// Field codes, edit-mode FSM states and the reference clock rate.
package reloj_pkg;

    localparam int CLK_HZ   = 100_000_000;
    localparam int N_CAMPOS = 6;

    localparam logic [3:0] CAMPO_NINGUNO = 4'd0;
    localparam logic [3:0] CAMPO_SS      = 4'd1;
    localparam logic [3:0] CAMPO_MM      = 4'd2;
    localparam logic [3:0] CAMPO_HH      = 4'd3;
    localparam logic [3:0] CAMPO_DD      = 4'd4;
    localparam logic [3:0] CAMPO_MES     = 4'd5;
    localparam logic [3:0] CAMPO_AA      = 4'd6;

    typedef enum logic {
        INACTIVO = 1'b0,
        EDITANDO = 1'b1
    } estado_t;

endpackage

// File: rtl/antirrebote.sv
// Push-button synchronizer + debouncer with a registered rising-edge tick.
// Latency: pin to tick-visible 2 + DEB_CYCLES cycles; level flips on the same edge the tick is set.
// No backpressure: free-running, one tick per debounced press.
module antirrebote #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic nivel,
    output logic flanco
);

    localparam int              CW      = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_FIN = CW'(DEB_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    // The counter only runs while the synchronized input disagrees with the
    // debounced level, so any bounce back to the old value restarts it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            cnt    <= '0;
            nivel  <= 1'b0;
            flanco <= 1'b0;
        end else begin
            s1     <= btn;
            s2     <= s1;
            flanco <= 1'b0;
            if (s2 == nivel) begin
                cnt <= '0;
            end else if (cnt == CNT_FIN) begin
                nivel  <= s2;
                flanco <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/control_edicion_botones.sv
// Edit-mode front end: debounced buttons, field select FSM, up/down ticks with auto-repeat.
// Latency: button pin to registered output 2 + DEB_CYCLES + 1 cycles.
// No backpressure: Arriba/Abajo are single-cycle pulses consumed every cycle by the field counters.
module control_edicion_botones #(
    parameter int DEB_CYCLES = 1_000_000,
    parameter int REP_DELAY  = 50_000_000,
    parameter int REP_PERIOD = 25_000_000,
    parameter int N_CAMPOS   = reloj_pkg::N_CAMPOS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_editar,
    input  logic       btn_izq,
    input  logic       btn_der,
    input  logic       btn_arriba,
    input  logic       btn_abajo,
    output logic [3:0] contadoresH,
    output logic       Arriba,
    output logic       Abajo,
    output logic       modo_edicion
);

    import reloj_pkg::*;

    localparam int            REP_MAX     = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int            RW          = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
    localparam logic [RW-1:0] FIN_DELAY   = RW'(REP_DELAY - 1);
    localparam logic [RW-1:0] FIN_PERIOD  = RW'(REP_PERIOD - 1);
    localparam logic [3:0]    ULTIMO      = 4'(N_CAMPOS);

    logic       fl_editar, fl_izq, fl_der, fl_arriba, fl_abajo;
    logic       niv_arriba, niv_abajo;
    logic [2:0] unused_nivel;

    antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_deb_editar (
        .clk(clk), .reset(reset), .btn(btn_editar), .nivel(unused_nivel[0]), .flanco(fl_editar));
    antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_deb_izq (
        .clk(clk), .reset(reset), .btn(btn_izq), .nivel(unused_nivel[1]), .flanco(fl_izq));
    antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_deb_der (
        .clk(clk), .reset(reset), .btn(btn_der), .nivel(unused_nivel[2]), .flanco(fl_der));
    antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_deb_arriba (
        .clk(clk), .reset(reset), .btn(btn_arriba), .nivel(niv_arriba), .flanco(fl_arriba));
    antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_deb_abajo (
        .clk(clk), .reset(reset), .btn(btn_abajo), .nivel(niv_abajo), .flanco(fl_abajo));

    estado_t       estado, estado_n;
    logic [3:0]    campo, campo_n;
    logic          arriba_n, abajo_n;
    logic [RW-1:0] rep_cnt, rep_cnt_n;
    logic          rep_act, rep_act_n;
    logic          rep_fase, rep_fase_n;
    logic          rep_dir, rep_dir_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado   <= INACTIVO;
            campo    <= CAMPO_NINGUNO;
            Arriba   <= 1'b0;
            Abajo    <= 1'b0;
            rep_cnt  <= '0;
            rep_act  <= 1'b0;
            rep_fase <= 1'b0;
            rep_dir  <= 1'b0;
        end else begin
            estado   <= estado_n;
            campo    <= campo_n;
            Arriba   <= arriba_n;
            Abajo    <= abajo_n;
            rep_cnt  <= rep_cnt_n;
            rep_act  <= rep_act_n;
            rep_fase <= rep_fase_n;
            rep_dir  <= rep_dir_n;
        end
    end

    // Priority: mode toggle, then field move, then up/down; anything that is
    // not an ongoing valid hold drops the repeat state.
    always_comb begin
        estado_n   = estado;
        campo_n    = campo;
        arriba_n   = 1'b0;
        abajo_n    = 1'b0;
        rep_cnt_n  = '0;
        rep_act_n  = 1'b0;
        rep_fase_n = 1'b0;
        rep_dir_n  = rep_dir;
        case (estado)
            INACTIVO: begin
                campo_n = CAMPO_NINGUNO;
                if (fl_editar) begin
                    estado_n = EDITANDO;
                    campo_n  = CAMPO_SS;
                end
            end
            EDITANDO: begin
                if (fl_editar) begin
                    estado_n = INACTIVO;
                    campo_n  = CAMPO_NINGUNO;
                end else if (fl_izq || fl_der) begin
                    if (fl_der && !fl_izq) begin
                        campo_n = (campo == ULTIMO) ? CAMPO_SS : campo + 1'b1;
                    end else if (fl_izq && !fl_der) begin
                        campo_n = (campo == CAMPO_SS) ? ULTIMO : campo - 1'b1;
                    end
                end else if (niv_arriba && niv_abajo) begin
                    rep_act_n = 1'b0;
                end else if (fl_arriba || fl_abajo) begin
                    arriba_n  = fl_arriba;
                    abajo_n   = !fl_arriba;
                    rep_act_n = 1'b1;
                    rep_dir_n = fl_arriba;
                end else if (rep_act && (rep_dir ? niv_arriba : niv_abajo)) begin
                    rep_act_n  = 1'b1;
                    rep_fase_n = rep_fase;
                    if (rep_cnt == (rep_fase ? FIN_PERIOD : FIN_DELAY)) begin
                        rep_fase_n = 1'b1;
                        arriba_n   = rep_dir;
                        abajo_n    = !rep_dir;
                    end else begin
                        rep_cnt_n = rep_cnt + 1'b1;
                    end
                end
            end
            default: begin
                estado_n = INACTIVO;
                campo_n  = CAMPO_NINGUNO;
            end
        endcase
    end

    assign contadoresH  = campo;
    assign modo_edicion = (estado == EDITANDO);

endmodule

// File: tb/tb_control_edicion_botones.sv
// Bench for control_edicion_botones with short debounce/repeat parameters.
module tb_control_edicion_botones;

    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RP  = 8;
    localparam int NC  = 6;

    localparam logic [4:0] M_EDITAR = 5'b00001;
    localparam logic [4:0] M_IZQ    = 5'b00010;
    localparam logic [4:0] M_DER    = 5'b00100;
    localparam logic [4:0] M_ARRIBA = 5'b01000;
    localparam logic [4:0] M_ABAJO  = 5'b10000;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] btns;
    logic [3:0] contadoresH;
    logic       Arriba, Abajo, modo_edicion;

    int ciclo  = 0;
    int checks = 0;
    int errors = 0;
    int campo_mod = 0;
    int exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) ciclo <= ciclo + 1;

    control_edicion_botones #(
        .DEB_CYCLES(DEB), .REP_DELAY(RD), .REP_PERIOD(RP), .N_CAMPOS(NC)
    ) dut (
        .clk(clk), .reset(reset),
        .btn_editar(btns[0]), .btn_izq(btns[1]), .btn_der(btns[2]),
        .btn_arriba(btns[3]), .btn_abajo(btns[4]),
        .contadoresH(contadoresH), .Arriba(Arriba), .Abajo(Abajo),
        .modo_edicion(modo_edicion)
    );

    task automatic sync_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        btns  = '0;
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (contadoresH !== 4'd0) begin errors++; $display("FAIL reset_campo: got %0d, expected 0", contadoresH); end
        checks++; if (Arriba !== 1'b0) begin errors++; $display("FAIL reset_arriba: got %b, expected 0", Arriba); end
        checks++; if (Abajo !== 1'b0) begin errors++; $display("FAIL reset_abajo: got %b, expected 0", Abajo); end
        checks++; if (modo_edicion !== 1'b0) begin errors++; $display("FAIL reset_modo: got %b, expected 0", modo_edicion); end
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (contadoresH !== 4'd0 || modo_edicion !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: campo=%0d modo=%b, expected 0/0", contadoresH, modo_edicion);
        end
    endtask

    task automatic test_editar();
        int t0, k;
        logic       e_modo;
        logic [3:0] e_campo;
        sync_edge();
        btns = M_EDITAR;
        t0   = ciclo;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            k       = ciclo - t0;
            e_modo  = (k >= 7);
            e_campo = (k >= 7) ? 4'd1 : 4'd0;
            checks++; if (modo_edicion !== e_modo) begin errors++; $display("FAIL editar_modo t=%0d: got %b, expected %b", k, modo_edicion, e_modo); end
            checks++; if (contadoresH !== e_campo) begin errors++; $display("FAIL editar_campo t=%0d: got %0d, expected %0d", k, contadoresH, e_campo); end
            if (k == 10) btns = '0;
        end
        repeat (10) @(negedge clk);
        campo_mod = 1;
    endtask

    task automatic test_campos();
        logic [4:0] masks [10];
        int t0, k, viejo, nuevo;
        masks = '{M_DER, M_DER, M_DER, M_DER, M_DER, M_DER, M_DER, M_IZQ, M_IZQ, M_IZQ | M_DER};
        for (int i = 0; i < 10; i++) begin
            viejo = campo_mod;
            if (masks[i] == M_DER)      nuevo = (viejo == NC) ? 1 : viejo + 1;
            else if (masks[i] == M_IZQ) nuevo = (viejo == 1) ? NC : viejo - 1;
            else                        nuevo = viejo;
            sync_edge();
            btns = masks[i];
            t0   = ciclo;
            for (int n = 0; n < 9; n++) begin
                @(negedge clk);
                k = ciclo - t0;
                if (k == 6) begin
                    checks++; if (contadoresH !== 4'(viejo)) begin errors++; $display("FAIL campo_antes #%0d: got %0d, expected %0d", i, contadoresH, viejo); end
                end
                if (k == 7) begin
                    checks++; if (contadoresH !== 4'(nuevo)) begin errors++; $display("FAIL campo_despues #%0d: got %0d, expected %0d", i, contadoresH, nuevo); end
                end
            end
            btns = '0;
            repeat (10) @(negedge clk);
            campo_mod = nuevo;
        end
    endtask

    task automatic test_arriba_repeat();
        int rep_t[6];
        int t0, k, e;
        rep_t = '{7, 27, 35, 43, 51, 59};
        exp_q.delete();
        sync_edge();
        btns = M_ARRIBA;
        t0   = ciclo;
        foreach (rep_t[i]) exp_q.push_back(t0 + rep_t[i]);
        for (int n = 0; n < 81; n++) begin
            @(negedge clk);
            k = ciclo - t0;
            if (Arriba) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL arriba_pulse: unexpected pulse at t=%0d", k);
                end else begin
                    e = exp_q.pop_front();
                    if (ciclo !== e) begin errors++; $display("FAIL arriba_pulse: pulse at t=%0d, expected t=%0d", k, e - t0); end
                end
            end
            checks++; if (Abajo !== 1'b0) begin errors++; $display("FAIL arriba_no_abajo t=%0d: got %b, expected 0", k, Abajo); end
            if (k == 60) btns = '0;
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL arriba_missing: %0d pulses not seen, expected 0 left", exp_q.size()); end
        checks++; if (contadoresH !== 4'(campo_mod)) begin errors++; $display("FAIL arriba_campo: got %0d, expected %0d", contadoresH, campo_mod); end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_abajo_rebote();
        int t0, k, e;
        exp_q.delete();
        sync_edge();
        btns = '0;
        t0   = ciclo;
        exp_q.push_back(t0 + 37);
        for (int n = 0; n < 66; n++) begin
            @(negedge clk);
            k = ciclo - t0;
            if (Abajo) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL abajo_pulse: unexpected pulse at t=%0d", k);
                end else begin
                    e = exp_q.pop_front();
                    if (ciclo !== e) begin errors++; $display("FAIL abajo_pulse: pulse at t=%0d, expected t=%0d", k, e - t0); end
                end
            end
            checks++; if (Arriba !== 1'b0) begin errors++; $display("FAIL abajo_no_arriba t=%0d: got %b, expected 0", k, Arriba); end
            if (k < 30)      btns = (((k / 2) % 2) == 1) ? M_ABAJO : 5'b0;
            else if (k < 45) btns = M_ABAJO;
            else             btns = '0;
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL abajo_missing: %0d pulses not seen, expected 0 left", exp_q.size()); end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_ambos();
        int t0, k;
        sync_edge();
        btns = M_ARRIBA | M_ABAJO;
        t0   = ciclo;
        for (int n = 0; n < 81; n++) begin
            @(negedge clk);
            k = ciclo - t0;
            checks++; if (Arriba !== 1'b0) begin errors++; $display("FAIL ambos_arriba t=%0d: got %b, expected 0", k, Arriba); end
            checks++; if (Abajo !== 1'b0) begin errors++; $display("FAIL ambos_abajo t=%0d: got %b, expected 0", k, Abajo); end
            if (k == 40) btns = M_ARRIBA;
            if (k == 70) btns = '0;
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_inactivo();
        int t0, k;
        sync_edge();
        btns = M_EDITAR;
        t0   = ciclo;
        for (int n = 0; n < 11; n++) begin
            @(negedge clk);
            k = ciclo - t0;
            if (k == 6) begin
                checks++; if (modo_edicion !== 1'b1) begin errors++; $display("FAIL salir_modo_antes: got %b, expected 1", modo_edicion); end
            end
            if (k == 7) begin
                checks++; if (modo_edicion !== 1'b0) begin errors++; $display("FAIL salir_modo: got %b, expected 0", modo_edicion); end
                checks++; if (contadoresH !== 4'd0) begin errors++; $display("FAIL salir_campo: got %0d, expected 0", contadoresH); end
            end
            if (k == 10) btns = '0;
        end
        repeat (10) @(negedge clk);
        sync_edge();
        btns = M_ARRIBA;
        t0   = ciclo;
        for (int n = 0; n < 41; n++) begin
            @(negedge clk);
            k = ciclo - t0;
            checks++; if (Arriba !== 1'b0) begin errors++; $display("FAIL inactivo_arriba t=%0d: got %b, expected 0", k, Arriba); end
        end
        btns = '0;
        repeat (10) @(negedge clk);
        sync_edge();
        btns = M_EDITAR;
        t0   = ciclo;
        for (int n = 0; n < 11; n++) begin
            @(negedge clk);
            k = ciclo - t0;
            if (k == 7) begin
                checks++; if (modo_edicion !== 1'b1) begin errors++; $display("FAIL reentrar_modo: got %b, expected 1", modo_edicion); end
                checks++; if (contadoresH !== 4'd1) begin errors++; $display("FAIL reentrar_campo: got %0d, expected 1", contadoresH); end
            end
            if (k == 10) btns = '0;
        end
        repeat (10) @(negedge clk);
        campo_mod = 1;
    endtask

    task automatic test_reset_mid();
        int t0, k, e;
        exp_q.delete();
        sync_edge();
        btns = M_ARRIBA;
        t0   = ciclo;
        exp_q.push_back(t0 + 7);
        for (int n = 0; n < 51; n++) begin
            @(negedge clk);
            k = ciclo - t0;
            if (Arriba) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL reset_mid_pulse: unexpected pulse at t=%0d", k);
                end else begin
                    e = exp_q.pop_front();
                    if (ciclo !== e) begin errors++; $display("FAIL reset_mid_pulse: pulse at t=%0d, expected t=%0d", k, e - t0); end
                end
            end
            if (k == 13) begin
                checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL reset_mid_missing: %0d pulses not seen, expected 0 left", exp_q.size()); end
                checks++; if (Abajo !== 1'b0) begin errors++; $display("FAIL reset_mid_abajo: got %b, expected 0", Abajo); end
            end
            if (k >= 13) begin
                checks++; if (Arriba !== 1'b0) begin errors++; $display("FAIL reset_mid_arriba t=%0d: got %b, expected 0", k, Arriba); end
                checks++; if (contadoresH !== 4'd0) begin errors++; $display("FAIL reset_mid_campo t=%0d: got %0d, expected 0", k, contadoresH); end
                checks++; if (modo_edicion !== 1'b0) begin errors++; $display("FAIL reset_mid_modo t=%0d: got %b, expected 0", k, modo_edicion); end
            end
            if (k == 12) reset = 1'b1;
            if (k == 14) reset = 1'b0;
        end
        btns = '0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_editar();
        test_campos();
        test_arriba_repeat();
        test_abajo_rebote();
        test_ambos();
        test_inactivo();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
